// File: rtl/packet_writer_if.sv
// packet_writer_if
//   Source-side flit stream feeding packet_writer.
//   src_data  : 32-bit flit; a head flit carries the packet length in [2:0]
//   src_valid : source offers src_data
//   src_ready : writer accepts; a flit moves when valid and ready are both high
// master modport is the packet producer, slave modport is the writer.
interface packet_writer_if;
   logic [31:0] src_data;
   logic        src_valid;
   logic        src_ready;

   modport master (output src_data, output src_valid, input src_ready);
   modport slave  (input src_data, input src_valid, output src_ready);
endinterface

// File: rtl/packet_writer.sv
// packet_writer
//   Collects one packet of 32-bit flits from a source, waits for the flit
//   buffer to report enough free slots, then writes the flits into the buffer
//   with a two-cycle SETUP/STROBE pattern per flit. Waits for the buffer's
//   packet acknowledge and retransmits the whole packet on timeout, dropping
//   it after MAX_RETRY retransmissions.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   src        : source flit stream (packet_writer_if.slave)
//   capacity   : free flit slots reported by the buffer
//   ack        : buffer acknowledges a complete packet (level)
//   flit_out   : flit presented to the buffer
//   write      : write strobe, high for one cycle per flit
//   busy       : a packet is held (state other than IDLE)
//   pkt_sent   : one-cycle pulse on acknowledge
//   pkt_drop   : one-cycle pulse when a packet is abandoned
//   len_err    : one-cycle pulse when a head flit has an illegal length
module packet_writer #(
   parameter int MAX_FLITS   = 7,
   parameter int ACK_TIMEOUT = 15,
   parameter int MAX_RETRY   = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   packet_writer_if.slave       src,
   input  logic [2:0]           capacity,
   input  logic                 ack,
   output logic [31:0]          flit_out,
   output logic                 write,
   output logic                 busy,
   output logic                 pkt_sent,
   output logic                 pkt_drop,
   output logic                 len_err
);
   localparam int                 DATA_W      = 32;
   localparam int                 TIMER_W     = $clog2(ACK_TIMEOUT + 1);
   localparam logic [2:0]         MAX_LEN     = 3'(MAX_FLITS);
   localparam logic [2:0]         RETRY_LIMIT = 3'(MAX_RETRY);
   localparam logic [TIMER_W-1:0] TIMEOUT     = TIMER_W'(ACK_TIMEOUT);

   // SETUP and STROBE are the two phases of sending one flit.
   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT_SPACE,
      SETUP,
      STROBE,
      WAIT_ACK
   } state_t;

   state_t             state;
   logic [DATA_W-1:0]  store [MAX_FLITS];
   logic [2:0]         len;
   logic [2:0]         idx;
   logic [2:0]         retry;
   logic [TIMER_W-1:0] timer;
   logic               xfer;
   logic [2:0]         head_len;

   assign xfer     = src.src_valid && src.src_ready;
   assign head_len = src.src_data[2:0];

   // The only combinational output: gated by rst_n so it reads 0 throughout reset.
   assign src.src_ready = rst_n && ((state == IDLE) || (state == LOAD));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         len      <= '0;
         idx      <= '0;
         retry    <= '0;
         timer    <= '0;
         flit_out <= '0;
         write    <= 1'b0;
         busy     <= 1'b0;
         pkt_sent <= 1'b0;
         pkt_drop <= 1'b0;
         len_err  <= 1'b0;
         for (int i = 0; i < MAX_FLITS; i++) begin
            store[i] <= '0;
         end
      end else begin
         pkt_sent <= 1'b0;
         pkt_drop <= 1'b0;
         len_err  <= 1'b0;
         write    <= 1'b0;

         case (state)
            IDLE: begin
               if (xfer) begin
                  if ((head_len == 3'd0) || (head_len > MAX_LEN)) begin
                     len_err <= 1'b1;
                  end else begin
                     store[0] <= src.src_data;
                     len      <= head_len;
                     idx      <= 3'd1;
                     busy     <= 1'b1;
                     state    <= (head_len == 3'd1) ? WAIT_SPACE : LOAD;
                  end
               end
            end

            LOAD: begin
               if (xfer) begin
                  store[idx] <= src.src_data;
                  idx        <= idx + 3'd1;
                  if (idx == len - 3'd1) begin
                     state <= WAIT_SPACE;
                  end
               end
            end

            // flit_out is loaded here so it is already valid in the first SETUP cycle.
            WAIT_SPACE: begin
               if (capacity >= len) begin
                  idx      <= 3'd0;
                  flit_out <= store[0];
                  state    <= SETUP;
               end
            end

            SETUP: begin
               write <= 1'b1;
               state <= STROBE;
            end

            STROBE: begin
               if (idx == len - 3'd1) begin
                  timer <= TIMER_W'(1);
                  state <= WAIT_ACK;
               end else begin
                  idx      <= idx + 3'd1;
                  flit_out <= store[idx + 3'd1];
                  state    <= SETUP;
               end
            end

            // ack is checked before expiry, so an ack on the last timer cycle still succeeds.
            WAIT_ACK: begin
               if (ack) begin
                  pkt_sent <= 1'b1;
                  retry    <= 3'd0;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else if (timer == TIMEOUT) begin
                  if (retry < RETRY_LIMIT) begin
                     retry <= retry + 3'd1;
                     state <= WAIT_SPACE;
                  end else begin
                     pkt_drop <= 1'b1;
                     retry    <= 3'd0;
                     busy     <= 1'b0;
                     state    <= IDLE;
                  end
               end else begin
                  timer <= timer + TIMER_W'(1);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end
endmodule
